axis_sched_mux: RTL and testbench
=================================

AXIS_SCHED_MUX -- requirements
Module: axis_sched_mux

Interface
REQ-001 Parameter DATA_WIDTH, default 64, sets the width of each stream's tdata.
REQ-002 Parameter KEEP_WIDTH, default DATA_WIDTH/8, sets the width of each stream's tkeep.
REQ-003 Parameter IF_COUNT, default 3, sets the number of input streams; the range is 2..4.
REQ-004 Parameter CNT_WIDTH, default 32, sets the width of each per-input packet counter.
REQ-005 Port clk, input, 1 bit: the single clock; all logic SHALL be rising-edge.
REQ-006 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 Port sel, input, 2 bits: the input index chosen by the upstream scheduler.
REQ-008 Port en, input, 1 bit: scheduler enable; sel is considered only when en=1.
REQ-009 Port s_axis_tdata, input, IF_COUNT*DATA_WIDTH bits: flattened input data; input i occupies slice i.
REQ-010 Port s_axis_tkeep, input, IF_COUNT*KEEP_WIDTH bits: flattened input byte enables.
REQ-011 Ports s_axis_tvalid, s_axis_tlast (input) and s_axis_tready (output), IF_COUNT bits each: one bit per input.
REQ-012 Ports m_axis_tdata (output, DATA_WIDTH), m_axis_tkeep (output, KEEP_WIDTH), m_axis_tvalid, m_axis_tlast (output, 1 bit each), m_axis_tready (input, 1 bit): the merged output stream.
REQ-013 Port eop, output, 1 bit: end-of-packet pulse that drives the scheduler's tlast input.
REQ-014 Port busy, output, 1 bit: high while a packet is locked.
REQ-015 Port pkt_count, output, IF_COUNT*CNT_WIDTH bits: flattened per-input count of completed packets.

Function
REQ-016 The block SHALL have two states: IDLE and ACTIVE.
REQ-017 In IDLE, every s_axis_tready bit SHALL be 0.
REQ-018 In IDLE, if en=1, sel<IF_COUNT and s_axis_tvalid[sel]=1, the block SHALL latch sel into cur_sel and enter ACTIVE on that edge; no beat is transferred in that cycle.
REQ-019 In IDLE, sel>=IF_COUNT, or en=0, SHALL leave the block in IDLE with no side effect.
REQ-020 In ACTIVE, s_axis_tready[cur_sel] SHALL equal the skid buffer's "not full" flag, and every other tready bit SHALL be 0.
REQ-021 In ACTIVE, changes on sel or en SHALL be ignored until the packet ends.
REQ-022 In ACTIVE, accepting an input beat with tlast=1 SHALL return the block to IDLE on that edge; s_axis_tready SHALL be 0 in the following cycle.
REQ-023 The output path SHALL be a 2-entry skid buffer with registered readiness and sustained throughput of 1 beat per cycle.
REQ-024 An accepted beat SHALL appear on m_axis one cycle later; tdata, tkeep and tlast SHALL be forwarded unmodified and in order.
REQ-025 While m_axis_tvalid=1 and m_axis_tready=0, the m_axis signals SHALL hold stable.
REQ-026 Lock for the next packet MAY occur while beats of the previous packet remain buffered; ordering across packets SHALL be preserved.
REQ-027 eop SHALL be 1 for exactly the cycles where m_axis_tvalid, m_axis_tready and m_axis_tlast are all 1.
REQ-028 pkt_count[cur_sel] SHALL increment by 1 on input acceptance of a tlast beat, and SHALL wrap modulo 2^CNT_WIDTH.
REQ-029 busy SHALL be 1 if and only if the state is ACTIVE.
REQ-030 A single-beat packet (tlast on the first beat) SHALL give IDLE -> ACTIVE -> IDLE and a count increment of 1.
REQ-031 When the buffer is full and the upstream tlast beat is pending, the transition to IDLE SHALL wait until that beat is accepted.

Reset
REQ-032 While rst=1, the block SHALL hold the state at IDLE, clear cur_sel to 0, and empty the skid buffer.
REQ-033 While rst=1, m_axis_tvalid, eop, busy and all s_axis_tready bits SHALL be 0, and all pkt_count fields SHALL be 0.
REQ-034 Reset asserted mid-packet SHALL discard buffered beats; the remainder of the truncated packet SHALL NOT be forwarded automatically.

Structure
REQ-035 The state encodings and default parameter values SHALL reside in the shared scheduler package/header used by the packet_scheduling blocks.
REQ-036 The skid buffer SHALL be a sub-module, axis_skid_buffer, parameterised by DATA_WIDTH and KEEP_WIDTH.

Verification
REQ-037 Directed test 1: sel=1, en=1, input 1 sends 4 beats with tlast on beat 4, m_axis_tready=1 -> 4 beats out in order, first beat one cycle after acceptance, eop pulses once, pkt_count[1]=1.
REQ-038 Directed test 2: input 2 sends a 1-beat packet -> busy high for 1 cycle, eop pulses once, pkt_count[2]=1.
REQ-039 Directed test 3: mid-packet sel switches 0 -> 2 -> input 0's packet completes intact, and s_axis_tready[2]=0 throughout.
REQ-040 Directed test 4: m_axis_tready toggles 1010... over an 8-beat packet -> no loss or duplication, and outputs hold stable while stalled.
REQ-041 Directed test 5: en=1 with sel=3 (IF_COUNT=3) -> block stays IDLE and all readys stay 0.
REQ-042 Directed test 6: rst pulsed after beat 2 of 5 -> m_axis_tvalid=0 next cycle, counters 0, state IDLE; a new packet afterwards passes cleanly.

Source files
------------

// File: rtl/axis_sched_mux_pkg.sv
// Shared definitions for the packet scheduling blocks: lock-state encoding,
// default stream geometry and a small selector range helper.
package axis_sched_mux_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_IF_COUNT   = 3;
  localparam int DEF_CNT_WIDTH  = 32;
  localparam int SEL_WIDTH      = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } sched_state_e;

  // True when the scheduler's index names an input that actually exists.
  function automatic logic selInRange(input logic [SEL_WIDTH-1:0] s, input int n);
    return (int'(s) < n);
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream skid buffer. The upstream ready comes straight from a
// flop, so no combinational path runs from i_mReady back to o_sReady, yet a
// continuously ready sink still sees one beat per cycle.
module axis_skid_buffer
  import axis_sched_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_sData,
  input  logic [KEEP_WIDTH-1:0] i_sKeep,
  input  logic                  i_sLast,
  input  logic                  i_sValid,
  output logic                  o_sReady,
  output logic [DATA_WIDTH-1:0] o_mData,
  output logic [KEEP_WIDTH-1:0] o_mKeep,
  output logic                  o_mLast,
  output logic                  o_mValid,
  input  logic                  i_mReady
);

  logic [DATA_WIDTH-1:0] r_outData;
  logic [KEEP_WIDTH-1:0] r_outKeep;
  logic                  r_outLast;
  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_skidData;
  logic [KEEP_WIDTH-1:0] r_skidKeep;
  logic                  r_skidLast;
  logic                  r_skidValid;
  logic                  r_sReady;

  logic w_inFire;
  logic w_outFree;
  logic w_skidValidNext;

  assign w_inFire        = i_sValid & r_sReady;
  assign w_outFree       = ~r_outValid | i_mReady;
  assign w_skidValidNext = w_outFree ? 1'b0 : (r_skidValid | w_inFire);

  // Output register refills from the skid entry first so beat order is kept;
  // a beat arriving while the output is stalled parks in the skid entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid  <= 1'b0;
      r_skidValid <= 1'b0;
      r_sReady    <= 1'b1;
    end else begin
      if (w_outFree) begin
        if (r_skidValid) begin
          r_outData  <= r_skidData;
          r_outKeep  <= r_skidKeep;
          r_outLast  <= r_skidLast;
          r_outValid <= 1'b1;
        end else begin
          r_outValid <= w_inFire;
          if (w_inFire) begin
            r_outData <= i_sData;
            r_outKeep <= i_sKeep;
            r_outLast <= i_sLast;
          end
        end
      end else if (w_inFire && !r_skidValid) begin
        r_skidData <= i_sData;
        r_skidKeep <= i_sKeep;
        r_skidLast <= i_sLast;
      end
      r_skidValid <= w_skidValidNext;
      r_sReady    <= ~w_skidValidNext;
    end
  end

  assign o_sReady = r_sReady;
  assign o_mData  = r_outData;
  assign o_mKeep  = r_outKeep;
  assign o_mLast  = r_outLast;
  assign o_mValid = r_outValid;

endmodule

// File: rtl/axis_sched_mux.sv
// Packet-granular AXI-Stream multiplexer driven by an external scheduler.
// Between packets it locks onto the input named by sel, forwards that whole
// packet through a skid buffer, then releases on the accepted tlast beat.
module axis_sched_mux
  import axis_sched_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int IF_COUNT   = DEF_IF_COUNT,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SEL_WIDTH-1:0]           sel,
  input  logic                           en,
  input  logic [IF_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [IF_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic [IF_COUNT-1:0]            s_axis_tvalid,
  input  logic [IF_COUNT-1:0]            s_axis_tlast,
  output logic [IF_COUNT-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  input  logic                           m_axis_tready,
  output logic                           eop,
  output logic                           busy,
  output logic [IF_COUNT*CNT_WIDTH-1:0]  pkt_count
);

  sched_state_e         r_state;
  logic [SEL_WIDTH-1:0] r_curSel;
  logic [CNT_WIDTH-1:0] r_pktCount [IF_COUNT];

  logic                  w_active;
  logic                  w_selOk;
  logic                  w_selValid;
  logic [DATA_WIDTH-1:0] w_inData;
  logic [KEEP_WIDTH-1:0] w_inKeep;
  logic                  w_inValid;
  logic                  w_inLast;
  logic                  w_inFire;
  logic                  w_bufReady;
  logic                  w_mValid;
  logic [IF_COUNT-1:0]   w_curMask;

  assign w_active = (r_state == ACTIVE) & ~rst;
  assign w_selOk  = selInRange(sel, IF_COUNT);

  // Route the locked input to the buffer and look up the scheduler's candidate.
  always_comb begin
    w_inData   = '0;
    w_inKeep   = '0;
    w_inValid  = 1'b0;
    w_inLast   = 1'b0;
    w_selValid = 1'b0;
    w_curMask  = '0;
    for (int i = 0; i < IF_COUNT; i++) begin
      if (r_curSel == SEL_WIDTH'(i)) begin
        w_inData     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_inKeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        w_inValid    = s_axis_tvalid[i];
        w_inLast     = s_axis_tlast[i];
        w_curMask[i] = 1'b1;
      end
      if (sel == SEL_WIDTH'(i)) begin
        w_selValid = s_axis_tvalid[i];
      end
    end
  end

  assign w_inFire      = w_active & w_inValid & w_bufReady;
  assign s_axis_tready = (w_active & w_bufReady) ? w_curMask : '0;

  // Lock FSM: a new input is chosen only between packets; the accepted tlast beat releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_curSel <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (en && w_selOk && w_selValid) begin
            r_curSel <= sel;
            r_state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (w_inFire && w_inLast) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Completed-packet counters tick when the tlast beat enters the buffer and wrap naturally.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IF_COUNT; i++) begin
      if (rst) begin
        r_pktCount[i] <= '0;
      end else if (w_inFire && w_inLast && (r_curSel == SEL_WIDTH'(i))) begin
        r_pktCount[i] <= r_pktCount[i] + CNT_WIDTH'(1);
      end
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH),
    .KEEP_WIDTH(KEEP_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_sData  (w_inData),
    .i_sKeep  (w_inKeep),
    .i_sLast  (w_inLast),
    .i_sValid (w_active & w_inValid),
    .o_sReady (w_bufReady),
    .o_mData  (m_axis_tdata),
    .o_mKeep  (m_axis_tkeep),
    .o_mLast  (m_axis_tlast),
    .o_mValid (w_mValid),
    .i_mReady (m_axis_tready)
  );

  assign m_axis_tvalid = w_mValid & ~rst;
  assign eop           = m_axis_tvalid & m_axis_tready & m_axis_tlast;
  assign busy          = w_active;

  for (genvar g = 0; g < IF_COUNT; g++) begin : g_cnt
    assign pkt_count[g*CNT_WIDTH +: CNT_WIDTH] = r_pktCount[g] & {CNT_WIDTH{~rst}};
  end

endmodule

// File: tb/tb_axis_sched_mux.sv
// Bench for axis_sched_mux: per-input packet sources, a packet-level model of
// the scheduler lock, and a scoreboard monitor on the merged output stream.
module tb_axis_sched_mux;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int N  = 3;
  localparam int CW = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      sel;
  logic            en;
  logic [N*DW-1:0] s_tdata;
  logic [N*KW-1:0] s_tkeep;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic [KW-1:0]   m_tkeep;
  logic            m_tvalid;
  logic            m_tlast;
  logic            m_tready;
  logic            eop;
  logic            busy;
  logic [N*CW-1:0] pkt_count;

  beat_t srcQ [N][$];
  beat_t expQ [$];
  int    errors = 0;
  int    checks = 0;
  bit    modelActive = 0;
  int    lockSel = 0;
  int    modelCount [N];
  bit    fireFlag [N];
  bit    genRandom = 0;
  bit    randValid = 0;
  bit    randCtrl = 0;
  int    readyMode = 0;
  int    eopCount = 0;
  int    busyCount = 0;

  always #5 clk = ~clk;

  axis_sched_mux #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .IF_COUNT(N), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .sel(sel), .en(en),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .eop(eop), .busy(busy), .pkt_count(pkt_count)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic genPacket(input int src, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data = {$urandom, $urandom};
      b.keep = KW'($urandom);
      b.last = (k == len - 1);
      srcQ[src].push_back(b);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic [1:0] s, input int rMode);
    @(posedge clk);
    #2;
    en = e;
    sel = s;
    readyMode = rMode;
  endtask

  task automatic waitIdle(input int budget);
    bit done;
    done = 0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      done = (srcQ[0].size() == 0) && (srcQ[1].size() == 0) && (srcQ[2].size() == 0) &&
             (expQ.size() == 0) && !busy && !m_tvalid;
    end
    checkOutput("drainTimeout", {63'b0, done}, 64'd1);
  endtask

  // Sources: hold each beat until accepted, optionally throttle valid, drive the sink ready.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       m_tready = 1'b1;
      1:       m_tready = ~m_tready;
      default: m_tready = ($urandom_range(2) != 0);
    endcase
    if (randCtrl) begin
      en  = ($urandom_range(3) != 0);
      sel = 2'($urandom_range(3));
    end
    for (int i = 0; i < N; i++) begin
      bit held;
      held = s_tvalid[i] && !fireFlag[i];
      if (fireFlag[i] && srcQ[i].size() > 0) void'(srcQ[i].pop_front());
      if (srcQ[i].size() == 0 && genRandom && $urandom_range(3) == 0)
        genPacket(i, int'($urandom_range(1, 6)));
      if (srcQ[i].size() == 0) begin
        s_tvalid[i] = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tkeep[i*KW +: KW] = '0;
        s_tlast[i] = 1'b0;
      end else begin
        if (!held) s_tvalid[i] = randValid ? ($urandom_range(2) != 0) : 1'b1;
        s_tdata[i*DW +: DW] = srcQ[i][0].data;
        s_tkeep[i*KW +: KW] = srcQ[i][0].keep;
        s_tlast[i] = srcQ[i][0].last;
      end
    end
  end

  // Packet-level model: whole packets are queued in lock order; readys only for the locked input.
  always @(negedge clk) begin
    if (rst) begin
      modelActive = 0;
      expQ.delete();
      for (int i = 0; i < N; i++) begin
        modelCount[i] = 0;
        fireFlag[i] = 0;
      end
      checkOutput("rstTvalid", {63'b0, m_tvalid}, 64'd0);
      checkOutput("rstBusy", {63'b0, busy}, 64'd0);
      checkOutput("rstEop", {63'b0, eop}, 64'd0);
      checkOutput("rstTready", {61'b0, s_tready}, 64'd0);
      checkOutput("rstCountZero", {63'b0, (pkt_count == '0)}, 64'd1);
    end else begin
      checkOutput("busy", {63'b0, busy}, {63'b0, modelActive});
      for (int i = 0; i < N; i++) begin
        fireFlag[i] = s_tvalid[i] & s_tready[i];
        if (!modelActive || i != lockSel) checkOutput("treadyUnlocked", {63'b0, s_tready[i]}, 64'd0);
      end
      if (modelActive) begin
        if (fireFlag[lockSel] && srcQ[lockSel].size() > 0 && srcQ[lockSel][0].last) begin
          modelActive = 0;
          modelCount[lockSel] = modelCount[lockSel] + 1;
        end
      end else if (en && int'(sel) < N && s_tvalid[sel]) begin
        lockSel = int'(sel);
        modelActive = 1;
        for (int k = 0; k < srcQ[lockSel].size(); k++) expQ.push_back(srcQ[lockSel][k]);
      end
    end
  end

  // Output monitor: pop the scoreboard on every handshake and check stall stability and eop.
  bit    prevStall = 0;
  beat_t prevBeat;
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 0;
    end else begin
      if (busy) busyCount++;
      if (eop) eopCount++;
      checkOutput("eop", {63'b0, eop},
                  {63'b0, (m_tvalid && m_tready && expQ.size() > 0) ? expQ[0].last : 1'b0});
      if (prevStall) begin
        checkOutput("stallValid", {63'b0, m_tvalid}, 64'd1);
        checkOutput("stallData", m_tdata, prevBeat.data);
        checkOutput("stallKeepLast", {55'b0, m_tkeep, m_tlast}, {55'b0, prevBeat.keep, prevBeat.last});
      end
      if (m_tvalid && m_tready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedBeat", {63'b0, m_tvalid}, 64'd0);
        end else begin
          beat_t e;
          e = expQ.pop_front();
          checkOutput("outData", m_tdata, e.data);
          checkOutput("outKeep", {56'b0, m_tkeep}, {56'b0, e.keep});
          checkOutput("outLast", {63'b0, m_tlast}, {63'b0, e.last});
        end
      end
      prevStall = m_tvalid && !m_tready;
      prevBeat = {m_tdata, m_tkeep, m_tlast};
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    beat_t firstBeat;
    int    e0;
    int    b0;
    int    fires;
    rst = 1'b1; en = 1'b0; sel = 2'd0; m_tready = 1'b1;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] test 1: four-beat packet on input 1");
    applyStimulus(0, 2'd1, 0);
    genPacket(1, 4);
    firstBeat = srcQ[1][0];
    e0 = eopCount;
    applyStimulus(1, 2'd1, 0);
    fires = 0;
    for (int c = 0; c < 20 && fires == 0; c++) begin
      @(negedge clk);
      if (s_tvalid[1] && s_tready[1]) fires = 1;
    end
    @(negedge clk);
    checkOutput("t1Latency", {63'b0, m_tvalid}, 64'd1);
    checkOutput("t1FirstData", m_tdata, firstBeat.data);
    waitIdle(200);
    checkOutput("t1Eop", 64'(eopCount - e0), 64'd1);
    checkOutput("t1Count", {32'b0, pkt_count[1*CW +: CW]}, 64'd1);

    $display("[TB] test 2: single-beat packet on input 2");
    applyStimulus(0, 2'd2, 0);
    genPacket(2, 1);
    e0 = eopCount;
    b0 = busyCount;
    applyStimulus(1, 2'd2, 0);
    waitIdle(200);
    checkOutput("t2Busy", 64'(busyCount - b0), 64'd1);
    checkOutput("t2Eop", 64'(eopCount - e0), 64'd1);
    checkOutput("t2Count", {32'b0, pkt_count[2*CW +: CW]}, 64'd1);

    $display("[TB] test 3: sel moves to 2 while input 0 is locked");
    applyStimulus(0, 2'd0, 0);
    genPacket(0, 5);
    genPacket(2, 3);
    applyStimulus(1, 2'd0, 0);
    applyStimulus(1, 2'd0, 0);
    applyStimulus(1, 2'd2, 0);
    waitIdle(300);
    checkOutput("t3Count0", {32'b0, pkt_count[0*CW +: CW]}, 64'd1);
    checkOutput("t3Count2", {32'b0, pkt_count[2*CW +: CW]}, 64'd2);

    $display("[TB] test 4: eight beats with toggling m_axis_tready");
    applyStimulus(0, 2'd0, 1);
    genPacket(0, 8);
    applyStimulus(1, 2'd0, 1);
    waitIdle(300);
    checkOutput("t4Count0", {32'b0, pkt_count[0*CW +: CW]}, 64'd2);
    applyStimulus(0, 2'd0, 0);

    $display("[TB] test 5: sel out of range");
    applyStimulus(1, 2'd3, 0);
    for (int i = 0; i < N; i++) genPacket(i, 2);
    repeat (5) begin
      @(negedge clk);
      checkOutput("t5Busy", {63'b0, busy}, 64'd0);
      checkOutput("t5Tready", {61'b0, s_tready}, 64'd0);
    end
    applyStimulus(1, 2'd0, 0);
    applyStimulus(1, 2'd1, 0);
    applyStimulus(1, 2'd2, 0);
    randCtrl = 1;
    waitIdle(500);
    randCtrl = 0;

    $display("[TB] test 6: reset after beat 2 of 5");
    applyStimulus(0, 2'd0, 0);
    genPacket(0, 5);
    applyStimulus(1, 2'd0, 0);
    fires = 0;
    for (int c = 0; c < 40 && fires < 2; c++) begin
      @(negedge clk);
      if (s_tvalid[0] && s_tready[0]) fires++;
    end
    checkOutput("t6TwoBeats", 64'(fires), 64'd2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    en = 1'b0;
    srcQ[0].delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6Tvalid", {63'b0, m_tvalid}, 64'd0);
    checkOutput("t6Busy", {63'b0, busy}, 64'd0);
    checkOutput("t6Counts", {63'b0, (pkt_count == '0)}, 64'd1);
    genPacket(1, 3);
    applyStimulus(1, 2'd1, 0);
    waitIdle(200);
    checkOutput("t6NewCount", {32'b0, pkt_count[1*CW +: CW]}, 64'd1);

    $display("[TB] random phase");
    randValid = 1;
    genRandom = 1;
    randCtrl = 1;
    readyMode = 2;
    repeat (1500) @(posedge clk);
    #2 genRandom = 0;
    waitIdle(4000);
    randCtrl = 0;
    for (int i = 0; i < N; i++)
      checkOutput("finalCount", {32'b0, pkt_count[i*CW +: CW]}, 64'(modelCount[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
